// File: rtl/pwm_compare_if.sv
// Duty-cycle handshake between a duty source and pwm_compare.
// master drives data/valid, slave returns ready.
interface pwm_compare_if #(
  parameter int G_WIDTH = 4
);
  logic [G_WIDTH:0] duty_data;
  logic             duty_valid;
  logic             duty_ready;

  modport master (
    output duty_data,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_data,
    input  duty_valid,
    output duty_ready
  );
endinterface

// File: rtl/pwm_compare.sv
// PWM comparator against an upstream free-running counter.
// Sticky period irq is built only with PWM_COMPARE_IRQ_EN.
module pwm_compare #(
  parameter int G_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [G_WIDTH-1:0] count_in,
  input  logic               enable,
  pwm_compare_if.slave       duty,
  input  logic               irq_clr,
  output logic               pwm_out,
  output logic               period_start,
  output logic               irq
);

  localparam logic [G_WIDTH:0] FULL =
    {1'b1, {G_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  state_t             state;
  logic [G_WIDTH-1:0] count_prev;
  logic [G_WIDTH:0]   pending;
  logic [G_WIDTH:0]   active_duty;
  logic [G_WIDTH:0]   duty_nx;
  logic               pending_full;
  logic               pend_nx;
  logic               wrap;
  logic               take;
  logic               load;
  logic               hit;

  // Wrap detect, buffer moves and the duty for the next compare
  always_comb begin
    wrap    = count_in < count_prev;
    take    = duty.duty_valid & duty.duty_ready;
    load    = pending_full & ((state == IDLE) | wrap);
    duty_nx = active_duty;
    if (load) begin
      duty_nx = pending[G_WIDTH] ? FULL : pending;
    end
    pend_nx = take | (pending_full & ~load);
    hit     = {1'b0, count_in} < duty_nx;
  end

  // Control FSM with registered pwm, period pulse and duty buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count_prev      <= '0;
      pending         <= '0;
      pending_full    <= 1'b0;
      active_duty     <= '0;
      duty.duty_ready <= 1'b0;
      pwm_out         <= 1'b0;
      period_start    <= 1'b0;
    end else begin
      count_prev      <= count_in;
      active_duty     <= duty_nx;
      pending_full    <= pend_nx;
      duty.duty_ready <= ~pend_nx;
      period_start    <= wrap & (state != IDLE);
      if (take) begin
        pending <= duty.duty_data;
      end
      pwm_out <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (wrap) begin
              state   <= RUN;
              pwm_out <= hit;
            end
          end
          RUN: pwm_out <= hit;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PWM_COMPARE_IRQ_EN
  // Sticky flag: set by a period pulse, cleared by irq_clr, set wins
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (period_start) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Scoreboard bench for pwm_compare: a cycle reference model
// pushes expected outputs, a monitor pops and compares.
module tb_pwm_compare;

  localparam int W = 4;

  typedef struct packed {
    logic pwm;
    logic ps;
    logic irq;
    logic rdy;
  } exp_t;

  typedef enum {M_IDLE, M_ARMED, M_RUN} mode_e;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         irq_clr;
  logic [W-1:0] count_in;
  logic         pwm_out;
  logic         period_start;
  logic         irq;

  pwm_compare_if #(.G_WIDTH(W)) bus ();

  pwm_compare #(.G_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .count_in     (count_in),
    .enable       (enable),
    .duty         (bus),
    .irq_clr      (irq_clr),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;

  // stimulus state
  logic [W-1:0] cnt = '0;
  int           hold = 0;
  bit           rst = 1'b1;
  bit           en  = 1'b0;
  bit           clr = 1'b0;
  bit           src_pend = 1'b0;
  logic [W:0]   src_data = '0;

  // reference model state
  mode_e m_mode = M_IDLE;
  int    m_prev = 0;
  int    m_active = 0;
  int    m_pend[$];
  exp_t  m_out = '0;

  task automatic check(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b expected %b",
               name, $time, act, exp);
    end
  endtask

  // Outputs after the coming edge, from the behavioural rules
  task automatic model_edge();
    exp_t nx;
    bit   w;
    bit   acc;
    int   v;
    nx = '0;
    if (rst) begin
      m_mode   = M_IDLE;
      m_prev   = 0;
      m_active = 0;
      m_pend.delete();
    end else begin
      w   = int'(cnt) < m_prev;
      acc = src_pend && m_out.rdy;
      if (m_pend.size() > 0 && (m_mode == M_IDLE || w)) begin
        v = m_pend.pop_front();
        m_active = (v > (1 << W)) ? (1 << W) : v;
      end
      if (acc) m_pend.push_back(int'(src_data));
      nx.ps = w && (m_mode != M_IDLE);
`ifdef PWM_COMPARE_IRQ_EN
      nx.irq = m_out.ps || (m_out.irq && !clr);
`endif
      if (!en) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_ARMED;
      else if (m_mode == M_ARMED && w) m_mode = M_RUN;
      nx.pwm = (m_mode == M_RUN) && (int'(cnt) < m_active);
      nx.rdy = (m_pend.size() == 0);
      m_prev = int'(cnt);
      if (acc) src_pend = 1'b0;
    end
    m_out = nx;
    exp_q.push_back(nx);
  endtask

  task automatic step();
    @(negedge clk);
    reset = rst;
    enable = en;
    irq_clr = clr;
    count_in = cnt;
    bus.duty_valid = src_pend;
    bus.duty_data = src_data;
    model_edge();
    if (hold > 0) begin
      cnt = '0;
      hold--;
    end else begin
      cnt = cnt + 1'b1;
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic offer(logic [W:0] d);
    src_data = d;
    src_pend = 1'b1;
  endtask

  task automatic until_cnt(logic [W-1:0] v);
    for (int i = 0; i < 40 && cnt != v; i++) step();
  endtask

  // Monitor: compare registered outputs just after each edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pwm_out", pwm_out, mon_e.pwm);
      check("period_start", period_start, mon_e.ps);
      check("irq", irq, mon_e.irq);
      check("duty_ready", bus.duty_ready, mon_e.rdy);
    end
  end

  initial begin
    int hi;
    reset = 1'b1;
    enable = 1'b0;
    irq_clr = 1'b0;
    count_in = '0;
    bus.duty_valid = 1'b0;
    bus.duty_data = '0;

    // reset, load duty 4 in IDLE, then run
    run(3);
    rst = 1'b0;
    offer(5'd4);
    run(3);
    en = 1'b1;
    run(40);

    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      @(posedge clk);
      #2;
      if (pwm_out === 1'b1) hi++;
    end
    n_tests++;
    if (hi != 4) begin
      n_fail++;
      $display("FAIL duty4_high_cycles got %0d expected 4", hi);
    end

    // constant low, constant high, saturation
    offer(5'd0);
    run(36);
    offer(5'd16);
    run(36);
    offer(5'd31);
    run(36);

    // update mid-period while running
    offer(5'd4);
    run(20);
    until_cnt(4'd7);
    offer(5'd8);
    run(40);

    // offer exactly in the wrap cycle
    until_cnt(4'd0);
    offer(5'd12);
    run(40);

    // upstream reset mid-period, then held at 0
    until_cnt(4'd9);
    cnt = '0;
    hold = 20;
    run(25);
    run(20);

    // irq clear with simultaneous period pulse
    until_cnt(4'd0);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    run(20);
    clr = 1'b1;
    run(3);
    clr = 1'b0;

    // reset mid-period, enable drop
    until_cnt(4'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(10);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(40);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (!src_pend && $urandom_range(0, 5) == 0)
        offer(5'($urandom_range(0, 31)));
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0) en = !en;
      clr = ($urandom_range(0, 3) == 0);
      if (hold == 0 && $urandom_range(0, 119) == 0) begin
        cnt = '0;
        hold = $urandom_range(0, 4);
      end
      step();
    end

    repeat (2) @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
